// File: rtl/traffic_pkg.sv
// Shared state codes and lamp encodings for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_B = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_A = 3'd5,
        WALK      = 3'd6,
        FLASH     = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks.
module tick_prescaler #(
    parameter int unsigned DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach signal controller with pedestrian walk and night flash.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 100000000,
    parameter int unsigned GREEN_TIME   = 30,
    parameter int unsigned MIN_GREEN    = 10,
    parameter int unsigned YELLOW_TIME  = 4,
    parameter int unsigned ALL_RED_TIME = 2,
    parameter int unsigned WALK_TIME    = 8,
    parameter int unsigned TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flash_en,
    input  logic       ped_req,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic       ped_walk,
    output logic [2:0] phase
);

    localparam logic [TIMER_W-1:0] G_LAST = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] M_LAST = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] Y_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] R_LAST = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] W_LAST = TIMER_W'(WALK_TIME - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [TIMER_W-1:0] dur_last;
    logic               tick;
    logic               done;
    logic               cut;
    logic               ped_pend;
    logic               from_ns;
    logic               flash_bit;
    logic               flash_nxt;
    logic               walk_entry;
    logic [2:0]         l1_nxt;
    logic [2:0]         l2_nxt;
    logic               walk_nxt;

    tick_prescaler #(.DIV(CLK_DIV)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        dur_last = '0;
        unique case (state)
            NS_GREEN, EW_GREEN:   dur_last = G_LAST;
            NS_YELLOW, EW_YELLOW: dur_last = Y_LAST;
            ALL_RED_A, ALL_RED_B: dur_last = R_LAST;
            WALK:                 dur_last = W_LAST;
            default:              dur_last = '0;
        endcase
    end

    assign done = tick && (timer == dur_last);
    // early green cut once minimum green has been served
    assign cut  = tick && ped_pend && (timer >= M_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            NS_GREEN:  if (done || cut) state_nxt = NS_YELLOW;
            NS_YELLOW: if (done) state_nxt = ped_pend ? WALK : ALL_RED_B;
            ALL_RED_B: if (done) state_nxt = EW_GREEN;
            EW_GREEN:  if (done || cut) state_nxt = EW_YELLOW;
            EW_YELLOW: if (done) state_nxt = ped_pend ? WALK : ALL_RED_A;
            ALL_RED_A: if (done) state_nxt = NS_GREEN;
            WALK:      if (done) state_nxt = from_ns ? ALL_RED_B : ALL_RED_A;
            default:   state_nxt = ALL_RED_A;
        endcase
        if (flash_en) state_nxt = FLASH;
    end

    always_comb begin
        timer_nxt = timer;
        if (state_nxt != state || state == FLASH) begin
            timer_nxt = '0;
        end else if (tick) begin
            timer_nxt = timer + TIMER_W'(1);
        end
    end

    assign walk_entry = (state_nxt == WALK) && (state != WALK);
    assign flash_nxt  = (state == FLASH && state_nxt == FLASH) ? (flash_bit ^ tick) : 1'b0;

    // lamps are decoded from the upcoming state so they register alongside it
    always_comb begin
        l1_nxt   = RED;
        l2_nxt   = RED;
        walk_nxt = 1'b0;
        unique case (state_nxt)
            NS_GREEN:  l1_nxt = GRN;
            NS_YELLOW: l1_nxt = YEL;
            EW_GREEN:  l2_nxt = GRN;
            EW_YELLOW: l2_nxt = YEL;
            WALK:      walk_nxt = 1'b1;
            FLASH: begin
                l1_nxt = flash_nxt ? YEL : OFF;
                l2_nxt = flash_nxt ? RED : OFF;
            end
            default: begin
                l1_nxt = RED;
                l2_nxt = RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALL_RED_A;
            timer     <= '0;
            ped_pend  <= 1'b0;
            from_ns   <= 1'b0;
            flash_bit <= 1'b0;
            light1    <= RED;
            light2    <= RED;
            ped_walk  <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            ped_pend  <= ped_req | (ped_pend & ~walk_entry);
            if (walk_entry) from_ns <= (state == NS_YELLOW);
            flash_bit <= flash_nxt;
            light1    <= l1_nxt;
            light2    <= l2_nxt;
            ped_walk  <= walk_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed segment checks of the signal controller with a short prescaler.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flash_en = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light1;
    logic [2:0] light2;
    logic [2:0] phase;
    logic       ped_walk;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_light_ctrl #(
        .CLK_DIV      (4),
        .GREEN_TIME   (5),
        .MIN_GREEN    (2),
        .YELLOW_TIME  (2),
        .ALL_RED_TIME (1),
        .WALK_TIME    (3),
        .TIMER_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flash_en (flash_en),
        .ped_req  (ped_req),
        .light1   (light1),
        .light2   (light2),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        int         len;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       walk;
    } seg_t;

    function automatic seg_t mk(input logic [2:0] ph, input int len);
        seg_t s;
        s.ph   = ph;
        s.len  = len;
        s.walk = 1'b0;
        s.l1   = 3'b100;
        s.l2   = 3'b100;
        case (ph)
            3'd0: s.l1 = 3'b001;
            3'd1: s.l1 = 3'b010;
            3'd3: s.l2 = 3'b001;
            3'd4: s.l2 = 3'b010;
            3'd6: s.walk = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic seg_t fl(input int len, input logic on);
        seg_t s;
        s.ph   = 3'd7;
        s.len  = len;
        s.l1   = on ? 3'b010 : 3'b000;
        s.l2   = on ? 3'b100 : 3'b000;
        s.walk = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input seg_t s);
        n_cmp++;
        if ({phase, light1, light2, ped_walk} !== {s.ph, s.l1, s.l2, s.walk}) begin
            n_bad++;
            $display("FAIL %s t=%0t got ph=%0d l1=%b l2=%b walk=%b want ph=%0d l1=%b l2=%b walk=%b",
                     name, $time, phase, light1, light2, ped_walk,
                     s.ph, s.l1, s.l2, s.walk);
        end
    endtask

    task automatic run(input string name, input seg_t s);
        for (int i = 0; i < s.len; i++) begin
            check(name, s);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flash_en = 1'b0;
        ped_req  = 1'b0;
        @(negedge clk);
        check("reset", mk(3'd5, 1));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    seg_t cyc[9];

    initial begin
        cyc[0] = mk(3'd5, 4);
        cyc[1] = mk(3'd0, 20);
        cyc[2] = mk(3'd1, 8);
        cyc[3] = mk(3'd2, 4);
        cyc[4] = mk(3'd3, 20);
        cyc[5] = mk(3'd4, 8);
        cyc[6] = mk(3'd5, 4);
        cyc[7] = mk(3'd0, 20);
        cyc[8] = mk(3'd1, 8);

        do_reset();
        for (int i = 0; i < 9; i++) run("cycle", cyc[i]);

        do_reset();
        run("p_ar", mk(3'd5, 4));
        ped_req = 1'b1;
        run("p_g0", mk(3'd0, 1));
        ped_req = 1'b0;
        run("p_gcut", mk(3'd0, 7));
        run("p_y", mk(3'd1, 8));
        run("p_walk", mk(3'd6, 12));
        run("p_arb", mk(3'd2, 4));
        run("p_ewg", mk(3'd3, 20));
        run("p_ewy", mk(3'd4, 8));
        run("p_ara", mk(3'd5, 4));

        do_reset();
        run("e_ar", mk(3'd5, 4));
        run("e_nsg", mk(3'd0, 20));
        run("e_nsy", mk(3'd1, 8));
        run("e_arb", mk(3'd2, 4));
        run("e_ewg", mk(3'd3, 16));
        ped_req = 1'b1;
        run("e_ewg4", mk(3'd3, 1));
        ped_req = 1'b0;
        run("e_ewgend", mk(3'd3, 3));
        run("e_ewy", mk(3'd4, 8));
        run("e_walk", mk(3'd6, 4));
        ped_req = 1'b1;
        run("e_walkreq", mk(3'd6, 1));
        ped_req = 1'b0;
        run("e_walkend", mk(3'd6, 7));
        run("e_ara", mk(3'd5, 4));
        run("e_nsgcut", mk(3'd0, 8));
        run("e_nsy2", mk(3'd1, 8));
        run("e_walk2", mk(3'd6, 12));
        run("e_arb2", mk(3'd2, 4));
        run("e_ewg2", mk(3'd3, 20));

        do_reset();
        run("f_ar", mk(3'd5, 4));
        run("f_nsg", mk(3'd0, 20));
        run("f_nsy", mk(3'd1, 4));
        flash_en = 1'b1;
        run("f_nsylast", mk(3'd1, 1));
        run("f_off0", fl(3, 1'b0));
        run("f_on0", fl(4, 1'b1));
        run("f_off1", fl(4, 1'b0));
        run("f_on1", fl(3, 1'b1));
        flash_en = 1'b0;
        run("f_on1end", fl(1, 1'b1));
        run("f_ara", mk(3'd5, 4));
        run("f_nsg2", mk(3'd0, 20));
        run("f_nsy2", mk(3'd1, 8));

        do_reset();
        run("r_ar", mk(3'd5, 4));
        run("r_nsg", mk(3'd0, 20));
        run("r_nsy", mk(3'd1, 8));
        run("r_arb", mk(3'd2, 4));
        ped_req = 1'b1;
        run("r_ewg0", mk(3'd3, 1));
        ped_req = 1'b0;
        run("r_ewg1", mk(3'd3, 2));
        #2 rst_n = 1'b0;
        #1 check("r_async", mk(3'd5, 1));
        @(negedge clk);
        rst_n = 1'b1;
        run("r_ara", mk(3'd5, 4));
        run("r_nsgfull", mk(3'd0, 20));
        run("r_nsy2", mk(3'd1, 8));
        run("r_arb2", mk(3'd2, 4));

        do_reset();
        run("x_ar", mk(3'd5, 4));
        run("x_nsg", mk(3'd0, 20));
        run("x_nsy", mk(3'd1, 7));
        ped_req  = 1'b1;
        flash_en = 1'b1;
        run("x_nsylast", mk(3'd1, 1));
        ped_req = 1'b0;
        run("x_flash", fl(3, 1'b0));
        flash_en = 1'b0;
        run("x_flashend", fl(1, 1'b0));
        run("x_ara", mk(3'd5, 4));
        run("x_nsgcut", mk(3'd0, 8));
        run("x_nsy2", mk(3'd1, 8));
        run("x_walk", mk(3'd6, 12));
        run("x_arb", mk(3'd2, 4));
        run("x_ewg", mk(3'd3, 20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
